mxint8_unbroadcast: RTL
=======================

# mxint8_unbroadcast

Sequential MXINT8-to-FP32 decoder, the inverse of the FP32-to-MXINT8 broadcast encoder. Accepts one MXINT8 block (shared 8-bit scale plus `BLOCK_SIZE` signed 8-bit elements) through a valid/ready handshake and buffers it. It then streams the block out as `BLOCK_SIZE` float32 words, one per handshake, in element-index order. It sits at the ALU result boundary, where MX-format blocks return to the scalar FP32 domain.

## Interface
- `BLOCK_SIZE`, default from `mxint8_includes.v` (32): elements per block.
- `SCALE_WIDTH` (8), `MXINT8_ELEMENT_WIDTH` (8), `FLOAT32_WIDTH` (32): shared macros from the include files. These are not overridable.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  input block valid.
- `o_ready`  out  1  decoder can accept a block this cycle.
- `i_scale`  in  8  shared E8M0 scale, bias 127; 0xFF means NaN.
- `i_mxint8_elements`  in  8 x `BLOCK_SIZE` (unpacked array)  two's-complement elements, 1.6 fixed point.
- `o_valid`  out  1  `o_float32` valid.
- `i_ready`  in  1  downstream accepts `o_float32` this cycle.
- `o_float32`  out  32  decoded element.
- `o_index`  out  clog2(`BLOCK_SIZE`)  index of the current element.
- `o_last`  out  1  high with `o_valid` when `o_index == BLOCK_SIZE-1`.

## Operation
- States:
  - IDLE: `o_ready=1`, `o_valid=0`.
  - EMIT: `o_valid=1`.
- Transitions:
  - IDLE→EMIT on `i_valid && o_ready`. The scale and all elements are captured into the block buffer and `idx` is set to 0.
  - In EMIT, each cycle with `i_ready` increments `idx`.
  - On the last handshake (`idx==BLOCK_SIZE-1 && i_ready`): if `i_valid`, capture the new block, reset `idx` to 0 and stay in EMIT. Otherwise go to IDLE.
- `o_ready = (state==IDLE) || (o_last && i_ready)`. This gives back-to-back blocks with no bubble.
- Decode of element `x` with scale `s`: value = x · 2^-6 · 2^(s-127).
  - `s==0xFF`: output 0x7FC00000 for every element, regardless of `x`.
  - `x==0`: output 0x00000000. Negative zero is never produced.
  - Otherwise:
    - sign = `x[7]`; mag = |x|, 8 bits unsigned (mag 128 for x = -128).
    - p = position of the leading one of mag (0..7).
    - Biased exponent e = s + p - 6, computed signed 10-bit.
  - Normal case, 1 ≤ e ≤ 254: exponent field = e; mantissa = (mag << (23-p))[22:0].
  - Subnormal case, e ≤ 0: exponent field 0; mantissa = mag << (s+16). The result is exact, with no rounding.
  - Overflow case, e == 255: only reachable with s=254, x=-128. Saturate to 0xFF7FFFFF, matching the encoder's clamp-don't-flag policy.
- Conversion is exact in all non-saturating cases; no rounding logic exists.

## Timing
- Reset values: state IDLE, `idx` 0, buffer 0, `o_valid` 0, `o_ready` 1, `o_float32` 0, `o_index` 0, `o_last` 0.
- Latency: a block accepted at edge N presents element 0 with `o_valid=1` in the cycle after edge N.
- `o_float32` is combinational from registered buffer and `idx` only. It has no combinational path from `i_valid`, `i_ready`, or the input data.
- Backpressure: while `o_valid && !i_ready`, `o_float32`, `o_index` and `o_last` hold stable.
- Throughput: one element per cycle. `BLOCK_SIZE` cycles per block under continuous `i_ready`.
- Input data is sampled only on the accept edge. Changes at any other time are ignored.
- Reset asserted mid-block: the block is discarded, and outputs go to their reset values immediately (asynchronously).

## Structure
- Shared constants stay in `scalar_includes.v` and `mxint8_includes.v`: field widths, `BLOCK_SIZE`, bias, NaN scale code. Add `FLOAT32_QNAN` (0x7FC00000) and `FLOAT32_MAX_NEG` (0xFF7FFFFF) there.
- One combinational sub-module, `mxint8_element_to_float32` (inputs: scale and element; output: float32), containing the leading-one detect and normal/subnormal/saturate logic. The top module holds the FSM, counter and buffer.

## Test plan
- Scale 127, elements {0x40, 0xC0, 0x01, 0x80, 0x00, ...}, `i_ready` tied 1 → 0x3F800000, 0xBF800000, 0x3C800000, 0xC0000000, 0x00000000 on consecutive cycles. `o_last` is high only on index `BLOCK_SIZE-1`.
- Scale 0, element 0x40 → 0x00400000 (subnormal). Scale 0, element 0x01 → 0x00010000.
- Scale 0xFF, arbitrary elements → every output 0x7FC00000. Scale 254, element 0x80 → 0xFF7FFFFF.
- Random `i_ready` toggling → outputs stable during stalls, no element dropped or duplicated, indices 0..`BLOCK_SIZE-1` in order.
- Two blocks with `i_valid` held high → second block's element 0 appears the cycle after the first block's last handshake; `o_ready` is high exactly in that last-handshake cycle.
- `i_rst` asserted at index 5 → `o_valid` drops immediately. After release, a new block restarts at index 0.

Source files
------------

// File: rtl/mxint8_unbroadcast_pkg.sv
// Shared constants and types for the MXINT8-to-FP32 unbroadcast decoder.
// Field widths, block size, special encodings and the FSM state type.
package mxint8_unbroadcast_pkg;

  localparam int unsigned SCALE_WIDTH          = 8;
  localparam int unsigned MXINT8_ELEMENT_WIDTH = 8;
  localparam int unsigned FLOAT32_WIDTH        = 32;
  localparam int unsigned MX_BLOCK_SIZE        = 32;
  localparam int unsigned ELEM_FRAC_BITS       = 6;
  localparam int unsigned FP32_EXP_WIDTH       = 8;
  localparam int unsigned FP32_MANT_WIDTH      = 23;

  localparam logic [SCALE_WIDTH-1:0]   NAN_SCALE       = 8'hFF;
  localparam logic [FLOAT32_WIDTH-1:0] FLOAT32_QNAN    = 32'h7FC0_0000;
  localparam logic [FLOAT32_WIDTH-1:0] FLOAT32_MAX_NEG = 32'hFF7F_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                       sign;
    logic [FP32_EXP_WIDTH-1:0]  exponent;
    logic [FP32_MANT_WIDTH-1:0] mantissa;
  } float32_t;

  // Index width that stays legal for a single-element block.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxint8_unbroadcast_element_to_float32.sv
// Combinational decode of one MXINT8 element (1.6 fixed point) with an E8M0
// shared scale into an exact IEEE-754 single.
module mxint8_element_to_float32
  import mxint8_unbroadcast_pkg::*;
(
  input  logic [SCALE_WIDTH-1:0]          i_scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_element,
  output logic [FLOAT32_WIDTH-1:0]        o_float32
);

  logic                       w_sign;
  logic [7:0]                 w_mag;
  logic [2:0]                 w_lead;
  logic signed [9:0]          w_exp;
  logic [4:0]                 w_sub_amt;
  logic [FP32_MANT_WIDTH-1:0] w_norm_mant;
  logic [FP32_MANT_WIDTH-1:0] w_sub_mant;
  float32_t                   w_fp;

  // -128 maps to magnitude 128, which still fits in 8 unsigned bits.
  assign w_sign = i_element[7];
  assign w_mag  = w_sign ? 8'(~i_element + 8'd1) : i_element;

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_mag[i]) w_lead = 3'(i);
    end
  end

  assign w_exp = $signed({2'b00, i_scale}) + $signed({7'b000_0000, w_lead})
               - 10'(signed'(ELEM_FRAC_BITS));

  // Leading one lands on the hidden bit; lower bits form the mantissa.
  assign w_norm_mant = 23'(31'(w_mag) << (5'd23 - 5'(w_lead)));

  // Subnormal only when scale is tiny (<= 6), so the 5-bit amount never wraps there.
  assign w_sub_amt  = 5'(i_scale) + 5'd16;
  assign w_sub_mant = 23'(32'(w_mag) << w_sub_amt);

  always_comb begin
    w_fp = '0;
    if (i_scale == NAN_SCALE) begin
      w_fp = float32_t'(FLOAT32_QNAN);
    end else if (w_mag == 8'd0) begin
      w_fp = '0;
    end else if (w_exp >= 10'sd255) begin
      w_fp = float32_t'(FLOAT32_MAX_NEG);
    end else if (w_exp >= 10'sd1) begin
      w_fp.sign     = w_sign;
      w_fp.exponent = w_exp[7:0];
      w_fp.mantissa = w_norm_mant;
    end else begin
      w_fp.sign     = w_sign;
      w_fp.exponent = '0;
      w_fp.mantissa = w_sub_mant;
    end
  end

  assign o_float32 = w_fp;

endmodule

// File: rtl/mxint8_unbroadcast.sv
// MXINT8 block to FP32 stream decoder: buffers one block on accept, then emits
// BLOCK_SIZE float32 words in index order with valid/ready flow control.
module mxint8_unbroadcast
  import mxint8_unbroadcast_pkg::*;
#(
  parameter  int unsigned BLOCK_SIZE = MX_BLOCK_SIZE,
  localparam int unsigned IDX_W      = idx_width(BLOCK_SIZE)
)
(
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [SCALE_WIDTH-1:0]          i_scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_mxint8_elements [BLOCK_SIZE],
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [FLOAT32_WIDTH-1:0]        o_float32,
  output logic [IDX_W-1:0]                o_index,
  output logic                            o_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  state_t                          r_state;
  state_t                          w_state_next;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                w_idx_next;
  logic [SCALE_WIDTH-1:0]          r_scale;
  logic [MXINT8_ELEMENT_WIDTH-1:0] r_elem [BLOCK_SIZE];
  logic                            w_load;
  logic                            w_last;

  assign w_last    = (r_state == ST_EMIT) && (r_idx == LAST_IDX);
  assign o_valid   = (r_state == ST_EMIT);
  assign o_last    = w_last;
  assign o_index   = r_idx;
  // Ready on the final handshake lets the next block follow with no bubble.
  assign o_ready   = (r_state == ST_IDLE) || (w_last && i_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_load       = 1'b1;
          w_idx_next   = '0;
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (i_ready) begin
          if (r_idx == LAST_IDX) begin
            w_idx_next = '0;
            if (i_valid) w_load       = 1'b1;
            else         w_state_next = ST_IDLE;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Block buffer and element counter; data is sampled only on an accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_scale <= '0;
      for (int i = 0; i < int'(BLOCK_SIZE); i++) r_elem[i] <= '0;
    end else begin
      r_idx <= w_idx_next;
      if (w_load) begin
        r_scale <= i_scale;
        r_elem  <= i_mxint8_elements;
      end
    end
  end

  mxint8_element_to_float32 u_decode (
    .i_scale   (r_scale),
    .i_element (r_elem[r_idx]),
    .o_float32 (o_float32)
  );

endmodule
